// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-builder memory arbiter.
//   state_e      : arbiter FSM encoding (Idle/Burst/Drain/Done)
//   DefWidth/Addr: default memory data/address widths
//   idx_width()  : bits needed for a requester index
//   tag_width()  : width of one read-tag record {valid, owner}
package matrix_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBurst = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefAddr  = 8;

  function automatic int unsigned idx_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // One tag-pipeline stage: valid bit on top, owner index below.
  function automatic int unsigned tag_width(input int unsigned nreq);
    return 1 + idx_width(nreq);
  endfunction

endpackage

// File: rtl/matrix_mem_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
//   req_i : request vector
//   ptr_i : index with highest priority; search proceeds upward modulo NREQ
//   any_o : at least one request is set
//   idx_o : first set request found starting at ptr_i
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            any_o,
  output logic [IdxW-1:0] idx_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  // Rotating right by ptr_i puts the highest-priority requester at bit 0.
  assign dbl   = {req_i, req_i};
  assign rot   = NREQ'(dbl >> ptr_i);
  assign any_o = |req_i;

  always_comb begin
    idx_o = '0;
    // Walk downward so the lowest offset (closest to ptr_i) is assigned last and wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (rot[off]) idx_o = IdxW'((int'(ptr_i) + off) % NREQ);
    end
  end

endmodule

// File: rtl/matrix_mem_arbiter.sv
// Round-robin burst arbiter sharing one memory read port between NREQ engines.
//   clk, rst_n          : clock, async active-low reset
//   req/req_base/req_len: per-requester burst request, base address, length (packed slices)
//   gnt, done           : one-hot grant held over the burst, one-cycle end-of-burst pulse
//   mem_rd/mem_addr     : memory read strobe and address
//   mem_data            : memory read data, RD_LAT cycles after mem_rd
//   rsp_valid/rsp_data  : one-hot response owner, data pass-through
//   busy                : FSM not idle
module matrix_mem_arbiter
  import matrix_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned ADDR   = DefAddr,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDR-1:0]  req_base,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  mem_rd,
  output logic [ADDR-1:0]       mem_addr,
  input  logic [WIDTH-1:0]      mem_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  localparam int unsigned IdxW = idx_width(NREQ);
  localparam int unsigned TagW = tag_width(NREQ);
  localparam int unsigned LatW = $clog2(RD_LAT + 1);

  state_e           state_q;
  logic [IdxW-1:0]  owner_q, rr_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [LatW-1:0]  dcnt_q;
  logic [NREQ-1:0]  gnt_q, done_q;
  logic             mem_rd_q, busy_q;
  logic [ADDR-1:0]  mem_addr_q;

  logic [RD_LAT-1:0][TagW-1:0] tag_q;

  logic             pick_any;
  logic [IdxW-1:0]  pick_idx;
  logic [ADDR-1:0]  pick_base;
  logic [LEN_W-1:0] pick_len;
  logic [NREQ-1:0]  pick_oh;

  rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Mux the winner's base/length; constant indices keep the slices simple.
  always_comb begin
    pick_base = '0;
    pick_len  = '0;
    pick_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IdxW'(i)) begin
        pick_base  = req_base[i*ADDR +: ADDR];
        pick_len   = req_len[i*LEN_W +: LEN_W];
        pick_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            owner_q    <= pick_idx;
            len_q      <= pick_len;
            cnt_q      <= '0;
            mem_addr_q <= pick_base;
            gnt_q      <= pick_oh;
            busy_q     <= 1'b1;
            if (pick_len != '0) begin
              state_q  <= StBurst;
              mem_rd_q <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= pick_oh;
            end
          end
        end
        StBurst: begin
          // cnt_q is the index of the read currently on the bus.
          if (cnt_q == len_q - LEN_W'(1)) begin
            mem_rd_q <= 1'b0;
            dcnt_q   <= '0;
            state_q  <= StDrain;
          end else begin
            cnt_q      <= cnt_q + LEN_W'(1);
            mem_addr_q <= mem_addr_q + ADDR'(1);
          end
        end
        StDrain: begin
          if (dcnt_q == LatW'(RD_LAT - 1)) begin
            state_q <= StDone;
            done_q  <= gnt_q;
          end else begin
            dcnt_q <= dcnt_q + LatW'(1);
          end
        end
        StDone: begin
          rr_q    <= (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + IdxW'(1);
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read tags travel alongside the memory latency so data is routed without
  // depending on the (possibly already changed) FSM owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= {mem_rd_q, owner_q};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = tag_q[RD_LAT-1][TagW-1] && (tag_q[RD_LAT-1][IdxW-1:0] == IdxW'(i));
    end
  end

  assign rsp_data = mem_data;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=1 and RD_LAT=3) with a simple memory model each.
module tb_matrix_mem_arbiter;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  req [2];
  logic [31:0] base_v [2];
  logic [31:0] len_v [2];
  logic [3:0]  gnt [2];
  logic [3:0]  done [2];
  logic        mem_rd [2];
  logic [7:0]  mem_addr [2];
  logic [15:0] mem_data [2];
  logic [3:0]  rsp_valid [2];
  logic [15:0] rsp_data [2];
  logic        busy [2];
  logic [7:0]  ap [2][3];

  exp_t q_rd [2][$];
  exp_t q_rsp [2][$];
  exp_t q_done [2][$];
  exp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_f(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Memory model: data for the address issued RD_LAT cycles earlier.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ap[d][0] <= mem_addr[d];
      ap[d][1] <= ap[d][0];
      ap[d][2] <= ap[d][1];
    end
  end
  assign mem_data[0] = mem_f(ap[0][0]);
  assign mem_data[1] = mem_f(ap[1][2]);

  matrix_mem_arbiter #(.NREQ(4), .WIDTH(16), .ADDR(8), .LEN_W(8), .RD_LAT(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req[0]),
    .req_base  (base_v[0]),
    .req_len   (len_v[0]),
    .gnt       (gnt[0]),
    .done      (done[0]),
    .mem_rd    (mem_rd[0]),
    .mem_addr  (mem_addr[0]),
    .mem_data  (mem_data[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_data  (rsp_data[0]),
    .busy      (busy[0])
  );

  matrix_mem_arbiter #(.NREQ(4), .WIDTH(16), .ADDR(8), .LEN_W(8), .RD_LAT(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req[1]),
    .req_base  (base_v[1]),
    .req_len   (len_v[1]),
    .gnt       (gnt[1]),
    .done      (done[1]),
    .mem_rd    (mem_rd[1]),
    .mem_addr  (mem_addr[1]),
    .mem_data  (mem_data[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_data  (rsp_data[1]),
    .busy      (busy[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a DUT presents a read, response or done.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("gnt_onehot", d, 32'($countones(gnt[d]) <= 1), 1);
      if (mem_rd[d]) begin
        if (q_rd[d].size() == 0) chk("rd_unexpected", d, 32'(mem_rd[d]), 0);
        else begin
          me = q_rd[d].pop_front();
          chk("rd_cycle", d, cyc, me.cyc);
          chk("rd_addr", d, 32'(mem_addr[d]), 32'(me.val));
          chk("rd_gnt", d, 32'(gnt[d]), 32'(me.vec));
        end
      end
      if (rsp_valid[d] != 4'b0) begin
        chk("rsp_owner", d, 32'(rsp_valid[d] & ~gnt[d]), 0);
        if (q_rsp[d].size() == 0) chk("rsp_unexpected", d, 32'(rsp_valid[d]), 0);
        else begin
          me = q_rsp[d].pop_front();
          chk("rsp_cycle", d, cyc, me.cyc);
          chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(me.vec));
          chk("rsp_data", d, 32'(rsp_data[d]), 32'(me.val));
        end
      end
      if (done[d] != 4'b0) begin
        chk("done_gnt", d, 32'(gnt[d]), 32'(done[d]));
        if (q_done[d].size() == 0) chk("done_unexpected", d, 32'(done[d]), 0);
        else begin
          me = q_done[d].pop_front();
          chk("done_cycle", d, cyc, me.cyc);
          chk("done_vec", d, 32'(done[d]), 32'(me.vec));
        end
      end
    end
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic push_burst(input int d, input int t, input int o, input logic [7:0] b,
                            input int l, input int nrd, input int nrsp, input bit dn);
    logic [3:0] oh;
    logic [7:0] a;
    exp_t e;
    oh = 4'b0001 << o;
    for (int k = 0; k < nrd; k++) begin
      a = 8'(b + k);
      e = '{t + 1 + k, oh, {8'h00, a}};
      q_rd[d].push_back(e);
    end
    for (int k = 0; k < nrsp; k++) begin
      a = 8'(b + k);
      e = '{t + 1 + k + lat_of(d), oh, mem_f(a)};
      q_rsp[d].push_back(e);
    end
    if (dn) begin
      e = '{(l == 0) ? t + 1 : t + l + lat_of(d) + 1, oh, 16'h0};
      q_done[d].push_back(e);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 200 && busy[d]; i++) begin
      @(posedge clk);
      #1;
    end
    chk("idle_wait", d, 32'(busy[d]), 0);
  endtask

  // Single-requester burst; inputs are scrambled after the grant to show they are ignored.
  task automatic burst(input int d, input int o, input logic [7:0] b, input int l);
    int t;
    wait_idle(d);
    base_v[d][o*8 +: 8] = b;
    len_v[d][o*8 +: 8]  = 8'(l);
    req[d][o] = 1'b1;
    t = cyc;
    push_burst(d, t, o, b, l, l, l, 1'b1);
    goto(t + 1);
    chk("gnt_at_t1", d, 32'(gnt[d]), 32'(4'b0001 << o));
    if (l == 0) chk("done_at_t1", d, 32'(done[d]), 32'(4'b0001 << o));
    req[d][o] = 1'b0;
    base_v[d][o*8 +: 8] = ~b;
    len_v[d][o*8 +: 8]  = 8'(l + 3);
    goto(t + ((l == 0) ? 1 : l + lat_of(d) + 1) + 1);
    chk("busy_end", d, 32'(busy[d]), 0);
    chk("gnt_end", d, 32'(gnt[d]), 0);
  endtask

  initial begin
    int t;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0;
      base_v[d] = '0;
      len_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, 32'(gnt[d]), 0);
      chk("rst_done", d, 32'(done[d]), 0);
      chk("rst_mem_rd", d, 32'(mem_rd[d]), 0);
      chk("rst_mem_addr", d, 32'(mem_addr[d]), 0);
      chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 0);
      chk("rst_busy", d, 32'(busy[d]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: all four requesters, len 2 -> grants 0,1,2,3,0 every 5 cycles.
    for (int i = 0; i < 4; i++) begin
      base_v[0][i*8 +: 8] = 8'(8'h20 + 8'h10 * i);
      len_v[0][i*8 +: 8]  = 8'd2;
    end
    req[0] = 4'b1111;
    t = cyc;
    for (int k = 0; k < 5; k++) begin
      push_burst(0, t + 5 * k, k % 4, 8'(8'h20 + 8'h10 * (k % 4)), 2, 2, 2, 1'b1);
    end
    goto(t + 21);
    req[0] = 4'b0000;

    burst(0, 0, 8'h10, 4);   // single burst
    burst(0, 1, 8'hFE, 4);   // address wrap
    burst(0, 2, 8'h55, 0);   // zero length

    // Reset during the third read of a len-8 burst.
    wait_idle(0);
    base_v[0][8 +: 8] = 8'h40;
    len_v[0][8 +: 8]  = 8'd8;
    req[0][1] = 1'b1;
    t = cyc;
    push_burst(0, t, 1, 8'h40, 8, 3, 2, 1'b0);
    goto(t + 1);
    req[0][1] = 1'b0;
    goto(t + 3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 0, 32'(gnt[0]), 0);
    chk("mid_rst_mem_rd", 0, 32'(mem_rd[0]), 0);
    chk("mid_rst_busy", 0, 32'(busy[0]), 0);
    chk("mid_rst_rsp_valid", 0, 32'(rsp_valid[0]), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_done", 0, 32'(done[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    burst(0, 3, 8'h80, 2);

    // Latency sweep on the RD_LAT=3 instance.
    burst(1, 2, 8'h30, 5);

    for (int i = 0; i < 50; i++) begin
      if (q_rd[0].size() + q_rsp[0].size() + q_done[0].size() +
          q_rd[1].size() + q_rsp[1].size() + q_done[1].size() == 0) break;
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++) begin
      chk("left_rd", d, q_rd[d].size(), 0);
      chk("left_rsp", d, q_rsp[d].size(), 0);
      chk("left_done", d, q_done[d].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
